mdio_phy_responder: RTL

- Synthesizable PHY-side MII management (MDIO, IEEE 802.3 clause 22) responder.
- It is the counterpart of the MIIM master inside eth_top: it answers the mdc/md frames that eth_top issues and holds a small PHY register file.
- It replaces the behavioural PHY's management path on the bench, and can be reused in the SoC PHY shim.
- Runs on the Wishbone clock domain. MDC and MDIO are sampled as asynchronous data.

---
 rtl/mdio_phy_responder.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mdio_phy_responder.sv
// PHY-side clause-22 MDIO responder: decodes management frames sampled on
// MDC rise events and serves a small PHY register file.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | counting preamble 1s; a 0 after a full preamble starts a frame
// ST     | expecting the second start bit (1)
// OP     | collecting the 2-bit opcode (10 read, 01 write)
// PHYAD  | collecting the 5-bit PHY address
// REGAD  | collecting the 5-bit register address, then dispatch
// TA     | turnaround: read drives 0 on bit 2, write checks 1 then 0
// WDATA  | shifting in 16 write data bits, commit on the last
// RDATA  | shifting out 16 read data bits, release the pad afterwards
// SKIP   | frame addressed to another PHY, sit out TA + data
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'h01,
    parameter int          NUM_REGS     = 8,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1619,
    parameter logic [15:0] REG0_DEFAULT = 16'h3100
) (
    input  logic clk,
    input  logic rst,
    input  logic mdc_i,
    input  logic md_i,
    output logic md_o,
    output logic md_oe,
    input  logic link_up_i,
    output logic wr_strobe_o,
    output logic rd_strobe_o,
    output logic frame_err_o
);

    localparam int              IDXW       = $clog2(NUM_REGS);
    localparam int              PCW        = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PCW-1:0]  PRE_MAX    = PCW'(PREAMBLE_MIN);
    localparam logic [5:0]      NUM_REGS_L = 6'(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
    } state_t;

    state_t         state, state_nxt;
    logic [4:0]     bit_cnt, bit_cnt_nxt;
    logic [PCW-1:0] pre_cnt, pre_cnt_nxt;
    logic           md_o_nxt, md_oe_nxt;
    logic           err_nxt, wr_nxt, rd_nxt;

    logic           mdc_s1, mdc_s2, mdc_q, md_s1, md_s2;
    logic           mdc_rise;

    logic [14:0]    shift_in;
    logic [15:0]    rd_shift;
    logic           is_read;
    logic           phy_match;
    logic [4:0]     regad;
    logic [15:0]    rw_regs [NUM_REGS];
    logic [4:0]     bits5;
    logic [15:0]    wdata;
    logic [15:0]    rd_value;
    logic           last_bit;

    // Two-flop synchronisers for the asynchronous MDC/MDIO inputs, plus edge history.
    always_ff @(posedge clk) begin
        mdc_s1 <= mdc_i;
        mdc_s2 <= mdc_s1;
        mdc_q  <= mdc_s2;
        md_s1  <= md_i;
        md_s2  <= md_s1;
    end

    assign mdc_rise = mdc_s2 & ~mdc_q;
    assign bits5    = {shift_in[3:0], md_s2};
    assign wdata    = {shift_in, md_s2};
    assign last_bit = (bit_cnt == 5'd0);

    // Read mux evaluated while the last register address bit is being sampled.
    always_comb begin
        rd_value = 16'h0000;
        if (bits5 == 5'd1)
            rd_value = 16'h7809 | {13'b0, link_up_i, 2'b0};
        else if (bits5 == 5'd2)
            rd_value = PHY_ID1;
        else if (bits5 == 5'd3)
            rd_value = PHY_ID2;
        else if ({1'b0, bits5} < NUM_REGS_L)
            rd_value = rw_regs[bits5[IDXW-1:0]];
    end

    // State, bit counter, preamble counter and registered pad/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= 5'd0;
            pre_cnt     <= '0;
            md_o        <= 1'b0;
            md_oe       <= 1'b0;
            wr_strobe_o <= 1'b0;
            rd_strobe_o <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            pre_cnt     <= pre_cnt_nxt;
            md_o        <= md_o_nxt;
            md_oe       <= md_oe_nxt;
            wr_strobe_o <= wr_nxt;
            rd_strobe_o <= rd_nxt;
            frame_err_o <= err_nxt;
        end
    end

    // Frame decoder: advances one step per MDC rise event; bit_cnt counts down to 0 on the last bit of a field.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        pre_cnt_nxt = pre_cnt;
        md_o_nxt    = md_o;
        md_oe_nxt   = md_oe;
        err_nxt     = 1'b0;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        if (mdc_rise) begin
            unique case (state)
                S_IDLE: begin
                    if (md_s2) begin
                        if (pre_cnt != PRE_MAX)
                            pre_cnt_nxt = pre_cnt + PCW'(1);
                    end else if (pre_cnt == PRE_MAX) begin
                        state_nxt   = S_ST;
                        pre_cnt_nxt = '0;
                    end else begin
                        pre_cnt_nxt = '0;
                    end
                end
                S_ST: begin
                    if (md_s2) begin
                        state_nxt   = S_OP;
                        bit_cnt_nxt = 5'd1;
                    end else begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                S_OP: begin
                    if (!last_bit) begin
                        bit_cnt_nxt = bit_cnt - 5'd1;
                    end else if (shift_in[0] != md_s2) begin
                        state_nxt   = S_PHYAD;
                        bit_cnt_nxt = 5'd4;
                    end else begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                S_PHYAD: begin
                    if (!last_bit) begin
                        bit_cnt_nxt = bit_cnt - 5'd1;
                    end else begin
                        state_nxt   = S_REGAD;
                        bit_cnt_nxt = 5'd4;
                    end
                end
                S_REGAD: begin
                    if (!last_bit) begin
                        bit_cnt_nxt = bit_cnt - 5'd1;
                    end else if (!phy_match) begin
                        state_nxt   = S_SKIP;
                        bit_cnt_nxt = 5'd17;
                    end else if (is_read) begin
                        state_nxt   = S_TA;
                        bit_cnt_nxt = 5'd0;
                        rd_nxt      = 1'b1;
                    end else begin
                        state_nxt   = S_TA;
                        bit_cnt_nxt = 5'd1;
                    end
                end
                S_TA: begin
                    if (is_read) begin
                        // Second turnaround bit is ours: drive 0, then the data follows.
                        md_oe_nxt   = 1'b1;
                        md_o_nxt    = 1'b0;
                        state_nxt   = S_RDATA;
                        bit_cnt_nxt = 5'd16;
                    end else if (!last_bit) begin
                        if (md_s2) begin
                            bit_cnt_nxt = 5'd0;
                        end else begin
                            state_nxt = S_IDLE;
                            err_nxt   = 1'b1;
                        end
                    end else if (!md_s2) begin
                        state_nxt   = S_WDATA;
                        bit_cnt_nxt = 5'd15;
                    end else begin
                        state_nxt = S_IDLE;
                        err_nxt   = 1'b1;
                    end
                end
                S_WDATA: begin
                    if (!last_bit) begin
                        bit_cnt_nxt = bit_cnt - 5'd1;
                    end else begin
                        state_nxt = S_IDLE;
                        wr_nxt    = 1'b1;
                    end
                end
                S_RDATA: begin
                    // 16 rises present data[15]..data[0]; the 17th releases the pad.
                    if (!last_bit) begin
                        md_o_nxt    = rd_shift[15];
                        bit_cnt_nxt = bit_cnt - 5'd1;
                    end else begin
                        md_oe_nxt = 1'b0;
                        md_o_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (!last_bit)
                        bit_cnt_nxt = bit_cnt - 5'd1;
                    else
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Field capture, read shifter and register file updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_in  <= '0;
            rd_shift  <= '0;
            is_read   <= 1'b0;
            phy_match <= 1'b0;
            regad     <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                rw_regs[i] <= (i == 0) ? REG0_DEFAULT : 16'h0000;
        end else if (mdc_rise) begin
            if (state inside {S_OP, S_PHYAD, S_REGAD, S_WDATA})
                shift_in <= {shift_in[13:0], md_s2};
            if (state == S_OP && last_bit)
                is_read <= shift_in[0] & ~md_s2;
            if (state == S_PHYAD && last_bit)
                phy_match <= (bits5 == PHY_ADDR);
            if (state == S_REGAD && last_bit) begin
                regad    <= bits5;
                rd_shift <= rd_value;
            end
            if (state == S_RDATA && !last_bit)
                rd_shift <= {rd_shift[14:0], 1'b0};
            if (wr_nxt) begin
                if (regad == 5'd0) begin
                    // Bit 15 is a self-clearing soft reset of every R/W register.
                    if (wdata[15]) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            rw_regs[i] <= (i == 0) ? REG0_DEFAULT : 16'h0000;
                    end else begin
                        rw_regs[0] <= wdata;
                    end
                end else if (regad >= 5'd4 && {1'b0, regad} < NUM_REGS_L) begin
                    rw_regs[regad[IDXW-1:0]] <= wdata;
                end
            end
        end
    end

endmodule
